// File: rtl/mem_stage.sv
// mem_stage -- memory access stage of the core pipeline.
//
// Takes one EX-stage result per accept. Non-memory results and misaligned
// accesses are written back on the next cycle with no RAM traffic. Aligned
// loads/stores move to BUSY, hold one data-RAM request until dram_ack, then
// produce a single writeback pulse.
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   ex_valid/ex_ld/ex_st          EX result present; load / store flags
//   ex_funct3                     [1:0] size (B/H/W/D), [2] unsigned load
//   ex_res                        ALU result = effective address
//   ex_wdata                      store data (low bits)
//   ex_rd_addr                    destination register
//   stall                         EX must hold while high (state BUSY)
//   dram_req/dram_we              RAM request / write enable
//   dram_addr                     doubleword-aligned address
//   dram_wmask/dram_wdata         bit-granular mask and lane-aligned data
//   dram_rdata/dram_ack           RAM read data / completion
//   wb_valid/wb_wen/wb_rd_addr    writeback valid, write enable, register
//   wb_data                       writeback data
//   misalign                      writeback is a misaligned-access report
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_ld,
  input  logic        ex_st,
  input  logic [2:0]  ex_funct3,
  input  logic [63:0] ex_res,
  input  logic [63:0] ex_wdata,
  input  logic [4:0]  ex_rd_addr,
  output logic        stall,
  output logic        dram_req,
  output logic        dram_we,
  output logic [63:0] dram_addr,
  output logic [63:0] dram_wmask,
  output logic [63:0] dram_wdata,
  input  logic [63:0] dram_rdata,
  input  logic        dram_ack,
  output logic        wb_valid,
  output logic        wb_wen,
  output logic [4:0]  wb_rd_addr,
  output logic [63:0] wb_data,
  output logic        misalign
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      stateReg;
  logic [2:0]  laneReg;
  logic [1:0]  sizeReg;
  logic        unsReg;
  logic        isLoadReg;

  logic        isMem;
  logic        misaligned;
  logic [1:0]  exSize;
  logic [5:0]  exShift;
  logic [63:0] sizeMask;
  logic [63:0] loadShifted;
  logic [63:0] loadData;

  // Request lines are pure decodes of the state register, so they rise and
  // fall exactly with BUSY.
  assign stall    = (stateReg == BUSY);
  assign dram_req = (stateReg == BUSY);

  always_comb begin
    exSize  = ex_funct3[1:0];
    exShift = {ex_res[2:0], 3'b000};
    isMem   = ex_ld | ex_st;

    case (exSize)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ex_res[0];
      2'b10:   misaligned = |ex_res[1:0];
      default: misaligned = |ex_res[2:0];
    endcase

    case (exSize)
      2'b00:   sizeMask = 64'h0000_0000_0000_00FF;
      2'b01:   sizeMask = 64'h0000_0000_0000_FFFF;
      2'b10:   sizeMask = 64'h0000_0000_FFFF_FFFF;
      default: sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase

    // Bring the addressed lane down to bit 0, then extend from the access size.
    loadShifted = dram_rdata >> {laneReg, 3'b000};
    case (sizeReg)
      2'b00:   loadData = {{56{!unsReg && loadShifted[7]}},  loadShifted[7:0]};
      2'b01:   loadData = {{48{!unsReg && loadShifted[15]}}, loadShifted[15:0]};
      2'b10:   loadData = {{32{!unsReg && loadShifted[31]}}, loadShifted[31:0]};
      default: loadData = loadShifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      laneReg    <= 3'd0;
      sizeReg    <= 2'd0;
      unsReg     <= 1'b0;
      isLoadReg  <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= 64'd0;
      dram_wmask <= 64'd0;
      dram_wdata <= 64'd0;
      wb_valid   <= 1'b0;
      wb_wen     <= 1'b0;
      wb_rd_addr <= 5'd0;
      wb_data    <= 64'd0;
      misalign   <= 1'b0;
    end else begin
      // Writeback is a single-cycle pulse unless a branch below re-arms it.
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
      misalign <= 1'b0;

      if (stateReg == IDLE) begin
        if (ex_valid) begin
          wb_rd_addr <= ex_rd_addr;
          if (!isMem || misaligned) begin
            // Pass-through result, or a misaligned access reported without
            // touching the RAM.
            wb_valid <= 1'b1;
            wb_data  <= ex_res;
            wb_wen   <= !isMem && (ex_rd_addr != 5'd0);
            misalign <= isMem;
          end else begin
            stateReg   <= BUSY;
            laneReg    <= ex_res[2:0];
            sizeReg    <= exSize;
            unsReg     <= ex_funct3[2];
            isLoadReg  <= ex_ld;
            dram_we    <= ex_st;
            dram_addr  <= {ex_res[63:3], 3'b000};
            dram_wmask <= sizeMask << exShift;
            dram_wdata <= ex_wdata << exShift;
          end
        end
      end else begin
        // Address/mask/data stay frozen for the whole BUSY period.
        if (dram_ack) begin
          stateReg <= IDLE;
          dram_we  <= 1'b0;
          wb_valid <= 1'b1;
          wb_wen   <= isLoadReg && (wb_rd_addr != 5'd0);
          wb_data  <= isLoadReg ? loadData : 64'd0;
        end
      end
    end
  end

endmodule
